// File: rtl/router_pkg.sv
// Shared types for the router packet receiver: FSM states, header fields and decode.
package router_pkg;

    localparam int PKT_DATA_W = 8;
    localparam int ADDR_W     = 2;
    localparam int LEN_W      = PKT_DATA_W - ADDR_W;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        PARITY,
        HOLD,
        DROP
    } rx_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } hdr_t;

    function automatic hdr_t hdr_decode(input logic [PKT_DATA_W-1:0] b);
        hdr_t h;
        h.addr = b[ADDR_W-1:0];
        h.len  = b[PKT_DATA_W-1:ADDR_W];
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_rx.sv
// Packet receiver: steers header/payload/parity bytes to a per-destination FIFO, checks parity.
// Writes are combinational in the consume cycle; a full FIFO parks one byte in a hold register and raises busy.
module router_pkt_rx
    import router_pkg::*;
#(
    parameter int DATA_W   = PKT_DATA_W,
    parameter int NUM_DEST = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pkt_valid,
    input  logic [DATA_W-1:0]   data_in,
    output logic                busy,
    output logic                err,
    input  logic [NUM_DEST-1:0] fifo_full,
    output logic [NUM_DEST-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic                pkt_done
);

    rx_state_e            state_q, state_d, ret_q, ret_d, nxt_state;
    logic [ADDR_W-1:0]    addr_q, addr_d, cur_addr;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [DATA_W-1:0]    par_q, par_d, hold_q, hold_d;
    logic                 err_q, err_d;
    hdr_t                 hdr;
    logic [NUM_DEST-1:0]  sel, wr_raw;
    logic                 cur_ok, cur_full, consume, done_raw;

    assign hdr = hdr_decode(data_in);

    // In IDLE the destination comes straight from the header byte on the bus.
    always_comb begin
        cur_addr = (state_q == IDLE) ? hdr.addr : addr_q;
        for (int i = 0; i < NUM_DEST; i++) begin
            sel[i] = (cur_addr == ADDR_W'(i));
        end
    end

    assign cur_ok   = |sel;
    assign cur_full = |(sel & fifo_full);

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        addr_d    = addr_q;
        len_d     = len_q;
        par_d     = par_q;
        hold_d    = hold_q;
        err_d     = err_q;
        nxt_state = state_q;
        consume   = 1'b0;
        wr_raw    = '0;
        wr_data   = data_in;
        done_raw  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pkt_valid) begin
                    consume = 1'b1;
                    addr_d  = hdr.addr;
                    len_d   = hdr.len;
                    par_d   = data_in;
                    err_d   = 1'b0;
                    if (hdr.len == '0) begin
                        nxt_state = PARITY;
                    end else begin
                        nxt_state = cur_ok ? PAYLOAD : DROP;
                    end
                end
            end
            PAYLOAD, DROP: begin
                if (pkt_valid) begin
                    consume   = 1'b1;
                    par_d     = par_q ^ data_in;
                    len_d     = len_q - LEN_W'(1);
                    nxt_state = (len_q == LEN_W'(1)) ? PARITY : state_q;
                end
            end
            PARITY: begin
                consume   = 1'b1;
                err_d     = !cur_ok || (data_in != par_q);
                nxt_state = IDLE;
                done_raw  = !cur_full;
            end
            HOLD: begin
                wr_data = hold_q;
                if (!cur_full) begin
                    wr_raw   = sel;
                    state_d  = ret_q;
                    done_raw = (ret_q == IDLE);
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropped packets have an empty sel, so they never write and never hold.
        if (consume) begin
            if (cur_full) begin
                hold_d  = data_in;
                ret_d   = nxt_state;
                state_d = HOLD;
            end else begin
                wr_raw  = sel;
                state_d = nxt_state;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            par_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            par_q   <= par_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Combinational strobes are forced low while reset is asserted.
    assign wr_en    = wr_raw & {NUM_DEST{resetn}};
    assign pkt_done = done_raw & resetn;
    assign busy     = (state_q == HOLD);
    assign err      = err_q;

endmodule

// File: tb/tb_router_pkt_rx.sv
// Bench for router_pkt_rx: directed packets plus random traffic against a packet-level write-stream model.
module tb_router_pkt_rx;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       busy, err, pkt_done;
    logic [2:0] fifo_full = '0;
    logic [2:0] wr_en;
    logic [7:0] wr_data;

    int n_err = 0;
    int n_chk = 0;

    // Expected write stream, in order: {dest[1:0], byte[7:0]}.
    logic [9:0] exp_q[$];
    int         done_cnt = 0;
    int         busy_cnt = 0;
    bit         rand_full = 1'b0;
    int         full_cnt = 0;
    logic [2:0] full_mask = '0;
    logic [7:0] pay[64];
    logic       prev_err = 1'b0;

    always #5 clk = ~clk;

    router_pkt_rx #(.DATA_W(8), .NUM_DEST(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .busy      (busy),
        .err       (err),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .pkt_done  (pkt_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observe each cycle shortly after the falling edge, once inputs are settled.
    initial begin : mon
        logic [9:0] e;
        int idx;
        forever begin
            @(negedge clk);
            #1;
            if (resetn) begin
                if (busy) busy_cnt++;
                if (pkt_done) done_cnt++;
                if (wr_en != 3'b000) begin
                    chk("wr_onehot", $countones(wr_en), 1);
                    chk("wr_when_full", wr_en & fifo_full, 0);
                    idx = 0;
                    for (int i = 0; i < 3; i++) if (wr_en[i]) idx = i;
                    if (exp_q.size() == 0) begin
                        chk("wr_extra", wr_en, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_dest", idx, e[9:8]);
                        chk("wr_dat", wr_data, e[7:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (full_cnt > 0) begin
            fifo_full = full_mask;
            full_cnt--;
        end else if (rand_full && $urandom_range(0, 2) == 0) begin
            fifo_full = 3'($urandom_range(1, 7));
        end else begin
            fifo_full = '0;
        end
    endtask

    // Present a byte until a rising edge with busy low has consumed it.
    task automatic send_byte(input logic [7:0] b, input logic v);
        logic bz;
        int   n;
        n = 0;
        data_in   = b;
        pkt_valid = v;
        do begin
            bz = busy;
            tick();
            n++;
        end while (bz && n < 200);
        if (bz) chk("busy_stuck", busy, 0);
    endtask

    function automatic logic [7:0] par_of(input logic [7:0] h);
        logic [7:0] p;
        p = h;
        for (int k = 0; k < int'(h[7:2]); k++) p = p ^ pay[k];
        return p;
    endfunction

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] par, input bit stalls, input int full_at);
        logic [1:0] a;
        int         n, d0, w;
        a  = h[1:0];
        n  = int'(h[7:2]);
        d0 = done_cnt;
        if (a != 2'b11) begin
            exp_q.push_back({a, h});
            for (int k = 0; k < n; k++) exp_q.push_back({a, pay[k]});
            exp_q.push_back({a, par});
        end
        chk("err_hold", err, prev_err);
        send_byte(h, 1'b1);
        chk("err_clr", err, 0);
        for (int k = 0; k < n; k++) begin
            if (stalls) begin
                repeat ($urandom_range(0, 2)) begin
                    pkt_valid = 1'b0;
                    data_in   = 8'($urandom);
                    tick();
                end
            end
            if (k == full_at) begin
                fifo_full = 3'b001 << a;
                full_mask = fifo_full;
                full_cnt  = 2;
            end
            send_byte(pay[k], 1'b1);
        end
        send_byte(par, 1'b0);
        pkt_valid = 1'b0;
        data_in   = '0;
        w = 0;
        while (busy && w < 200) begin
            tick();
            w++;
        end
        chk("drain_busy", busy, 0);
        #2;
        prev_err = (a == 2'b11) || (par != par_of(h));
        chk("err_end", err, prev_err);
        chk("pkt_done_cnt", done_cnt - d0, 1);
        chk("writes_left", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int b0;
        logic [7:0] h;
        logic [7:0] p;

        // Reset with a header-looking byte on the bus: nothing may leak out.
        pkt_valid = 1'b1;
        data_in   = 8'h0D;
        repeat (3) tick();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", pkt_done, 0);
        pkt_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Good packet to dest 1.
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        b0 = busy_cnt;
        send_pkt(8'h0D, 8'hAD, 1'b0, -1);
        chk("t1_busy_cycles", busy_cnt - b0, 0);

        // Bad parity: all bytes still written, err raised and held.
        send_pkt(8'h0D, 8'hAC, 1'b0, -1);

        // Dest 0, len 4, FIFO full for 3 cycles starting at the 2nd payload byte.
        for (int k = 0; k < 4; k++) pay[k] = 8'($urandom);
        b0 = busy_cnt;
        send_pkt(8'h10, par_of(8'h10), 1'b0, 1);
        chk("t3_busy_cycles", busy_cnt - b0, 3);

        // Invalid address 3: dropped, err after parity.
        pay[0] = 8'h55;
        send_pkt(8'h07, par_of(8'h07), 1'b0, -1);

        // Zero-length packet to dest 2.
        send_pkt(8'h02, 8'h02, 1'b0, -1);

        // Reset in the middle of a packet.
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        exp_q.push_back({2'd1, 8'h0D});
        exp_q.push_back({2'd1, 8'hA1});
        exp_q.push_back({2'd1, 8'hA2});
        send_byte(8'h0D, 1'b1);
        send_byte(8'hA1, 1'b1);
        data_in   = 8'hA2;
        pkt_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_done", pkt_done, 0);
        pkt_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        resetn   = 1'b1;
        prev_err = 1'b0;
        tick();
        pay[0] = 8'h3C;
        send_pkt(8'h05, 8'h39, 1'b0, -1);

        // Random traffic with random FIFO back-pressure and source stalls.
        rand_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            h = {6'($urandom_range(0, 8)), 2'($urandom_range(0, 3))};
            for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
            p = par_of(h);
            if ($urandom_range(0, 3) == 0) p = p ^ 8'($urandom_range(1, 255));
            send_pkt(h, p, 1'b1, -1);
        end
        rand_full = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/router_pkt_rx.md
Name: router_pkt_rx

Overview:
- Router-side receiver for the source packet protocol (pkt_valid / data_in / busy / err).
- Decodes the header byte and steers header, payload and parity bytes into one of NUM_DEST destination FIFOs.
- Back-pressures the source with busy when the selected FIFO is full, using a one-byte hold register.
- Checks packet parity and reports mismatches on err.

Parameters:
- DATA_W, 8: byte width. Header layout: bits [1:0] = destination address, bits [DATA_W-1:2] = payload length.
- NUM_DEST, 3: number of destination FIFOs. Address value 3 is invalid.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- pkt_valid  input  1  source marks header/payload bytes valid
- data_in  input  DATA_W  source byte stream
- busy  output  1  receiver cannot consume data_in this cycle
- err  output  1  parity mismatch or invalid address on last packet
- fifo_full  input  NUM_DEST  per-destination FIFO full flags
- wr_en  output  NUM_DEST  one-hot FIFO write strobe
- wr_data  output  DATA_W  byte being written
- pkt_done  output  1  single-cycle pulse when parity byte is written or dropped

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; busy=0, err=0, wr_en=0, pkt_done=0.
  - Length counter, running parity, address and hold register cleared.
  - An in-flight packet is discarded; the next pkt_valid byte after release is decoded as a header.
- Consume rule: a byte is consumed at a rising edge when busy=0 and either:
  - pkt_valid=1 in IDLE, PAYLOAD or DROP; or
  - the state is PARITY, regardless of pkt_valid (source drops pkt_valid on the parity byte).
- busy is a Moore output: busy=1 only in HOLD. No combinational path from pkt_valid or data_in to busy.
- wr_en is combinational:
  - On consume with address a valid: wr_en[a] = !fifo_full[a], and wr_data = data_in.
  - In HOLD: wr_en[a] = !fifo_full[a], and wr_data = hold register.
- IDLE, header consumed:
  - Latch addr=data_in[1:0] and len=data_in[DATA_W-1:2]; parity := data_in; clear err.
  - addr=3: no write, go DROP.
  - Otherwise next state is PAYLOAD if len>0, else PARITY.
- PAYLOAD:
  - Each consumed byte: parity ^= byte, len decrements.
  - After the byte with len==1 is consumed, go PARITY.
  - pkt_valid=0 in PAYLOAD is a stall cycle: no consume, no error.
- PARITY:
  - Consume the parity byte and write it to the FIFO.
  - err is set the cycle after if the byte != running parity.
  - pkt_done pulses in the consume cycle; go IDLE.
- Full handling (IDLE, PAYLOAD or PARITY):
  - If consumed with fifo_full[addr]=1: capture the byte into the hold register, record the return state (the normal next state), go HOLD.
  - Parity and length update at consume time, not at write time.
- HOLD:
  - busy=1; data_in ignored.
  - On the first cycle with fifo_full[addr]=0: write the held byte, return to the saved state.
  - busy drops the cycle after the write.
  - If the held byte is the parity byte, pkt_done pulses in the write cycle.
- DROP (address 3):
  - Consume per the same length rule with no writes; then consume the parity byte (PARITY logic with writes suppressed).
  - err=1 the cycle after; pkt_done pulses.
- err is a level output: held from set until the next header is consumed or reset.
- No loss and no duplication: exactly 1 + len + 1 writes per valid packet.

Decomposition:
- router_pkg:
  - rx_state_e enum: IDLE, PAYLOAD, PARITY, HOLD, DROP.
  - ADDR_INVALID=2'b11.
  - Header field widths.
  - Header decode function returning {addr, len}.
- No sub-module: the hold register, counter and parity logic stay inline.

Test Plan:
- Addr 1, header 0x0D, payload A1 A2 A3, parity 0xAD, fifo_full=0 -> wr_en[1] high 5 cycles with data 0D A1 A2 A3 AD; busy=0 throughout; err=0; one pkt_done.
- Same packet with parity 0xAC -> all 5 bytes written; err=1 from the cycle after parity until the next header is consumed.
- Addr 0, len 4, fifo_full[0]=1 for 3 cycles during the 2nd payload byte -> byte held; busy=1 for 3 cycles; written exactly once when full clears; FIFO sequence intact; err=0.
- Header 0x07 (addr 3, len 1) + 1 payload + parity -> wr_en never asserted; err=1 after parity; pkt_done pulses.
- Addr 2, header 0x02 (len 0), parity 0x02 -> 2 writes to wr_en[2]; err=0; IDLE reached on the next cycle.
- resetn low during 2nd payload byte -> busy, err, wr_en and pkt_done go 0 immediately; after release, the next pkt_valid byte (0x05) is decoded as a header to dest 1, len 1.
